alu_multiword_seq: RTL and testbench

// - Sequencer (initiator side) of the parameterised W-bit ripple ALU interface.
// - Performs N*W-bit add/sub by streaming W-bit chunks LSB-first through one

---
 rtl/alu_multiword_seq.sv | 147 ++++++++++++++
 tb/tb_alu_multiword_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_multiword_seq.sv
// Multi-word add/sub sequencer: streams W-bit chunks LSB-first through one external ALU.
// Optional signed-overflow output enabled by defining ALU_SEQ_OVF_EN.
module alu_multiword_seq #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           op_sub,
    input  logic           cin,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] sum,
    output logic           c_out,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    output logic [2:0]     alu_op,
    output logic           alu_c_in,
    input  logic [W-1:0]   alu_result,
    input  logic           alu_c_out
`ifdef ALU_SEQ_OVF_EN
    ,
    output logic           ovf
`endif
);

    localparam int KW = $clog2(N);
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [KW-1:0]  k_q, k_d;
    logic [N*W-1:0] a_q, a_d;
    logic [N*W-1:0] b_q, b_d;
    logic           carry_q, carry_d;
    logic [N*W-1:0] sum_q, sum_d;
    logic           c_out_q, c_out_d;
    logic           done_q, done_d;
`ifdef ALU_SEQ_OVF_EN
    logic           ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        done_d  = 1'b0;
`ifdef ALU_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    // SUB is A + ~B + 1 so the carry chains cleanly across chunks
                    a_d     = a_in;
                    b_d     = op_sub ? ~b_in : b_in;
                    carry_d = op_sub | cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*W +: W] = alu_result;
                carry_d = alu_c_out;
                if (k_q == K_LAST) begin
                    c_out_d = alu_c_out;
`ifdef ALU_SEQ_OVF_EN
                    ovf_d = (a_q[N*W-1] ^ alu_result[W-1])
                          & (b_q[N*W-1] ^ alu_result[W-1]);
`endif
                    k_d     = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            done_q  <= 1'b0;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            done_q  <= done_d;
`ifdef ALU_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_c_in = 1'b0;
        if (state_q == RUN) begin
            alu_a    = a_q[int'(k_q)*W +: W];
            alu_b    = b_q[int'(k_q)*W +: W];
            alu_c_in = carry_q;
        end
    end

    assign alu_op = 3'b010;
    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign sum    = sum_q;
    assign c_out  = c_out_q;
`ifdef ALU_SEQ_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Scoreboard bench for alu_multiword_seq with W=8, N=4 and a behavioural ADD ALU.
module tb_alu_multiword_seq;

    localparam int W = 8;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          op_sub;
    logic          cin;
    logic [31:0]   a_in;
    logic [31:0]   b_in;
    logic          busy;
    logic          done;
    logic [31:0]   sum;
    logic          c_out;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic          alu_c_in;
    logic [W-1:0]  alu_result;
    logic          alu_c_out;
`ifdef ALU_SEQ_OVF_EN
    logic          ovf;
`endif

    alu_multiword_seq #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op_sub(op_sub), .cin(cin),
        .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .sum(sum),
        .c_out(c_out), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_c_in(alu_c_in), .alu_result(alu_result), .alu_c_out(alu_c_out)
`ifdef ALU_SEQ_OVF_EN
        , .ovf(ovf)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU, ADD only
    assign {alu_c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b} + 9'(alu_c_in);

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: pops an expectation whenever done is presented
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (done) begin
            done_cnt++;
            if (prev_done) check("done_single_pulse", 32'(prev_done), 32'd0);
            if (q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = q.pop_front();
                check("sum", sum, e.s);
                check("c_out", 32'(c_out), 32'(e.c));
                check("latency", 32'(cyc - e.t0), 32'(N));
`ifdef ALU_SEQ_OVF_EN
                check("ovf", 32'(ovf), 32'(e.o));
`endif
            end
        end
        prev_done = done;
    end

    task automatic issue(bit sub, bit ci, logic [31:0] a, logic [31:0] b,
                         logic [31:0] es, bit ec, bit eo, bit push);
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            check("issue_timeout", 32'(busy), 32'd0);
            return;
        end
        op_sub = sub;
        cin    = ci;
        a_in   = a;
        b_in   = b;
        start  = 1'b1;
        @(posedge clk);
        #1;
        if (push) q.push_back('{es, ec, eo, cyc});
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy || q.size() != 0) check("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int dc;
        rst    = 1'b1;
        start  = 1'b0;
        op_sub = 1'b0;
        cin    = 1'b0;
        a_in   = '0;
        b_in   = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", sum, 32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_b", 32'(alu_b), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd2);
        check("rst_alu_c_in", 32'(alu_c_in), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        issue(0, 0, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 1);
        issue(0, 0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 1);
        issue(0, 1, 32'h00000001, 32'h00000001, 32'h00000003, 0, 0, 1);
        issue(1, 0, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 0, 0, 1);
        issue(1, 1, 32'h12345678, 32'h12345678, 32'h00000000, 1, 0, 1);
        issue(0, 0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 1, 1);
        issue(1, 0, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 1, 1);
        issue(0, 0, 32'h00000001, 32'h00000001, 32'h00000002, 0, 0, 1);
        wait_idle();

        // start during RUN must be ignored
        dc = done_cnt;
        issue(0, 0, 32'h0000AAAA, 32'h00005555, 32'h0000FFFF, 0, 0, 1);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        op_sub = 1'b0;
        a_in   = 32'h11111111;
        b_in   = 32'h22222222;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("busy_start_ignored", 32'(done_cnt - dc), 32'd1);
        check("no_restart", 32'(busy), 32'd0);

        // reset after chunk 1 aborts with no done pulse
        dc = done_cnt;
        issue(0, 0, 32'h01020304, 32'h01010101, 32'h0, 0, 0, 0);
        @(posedge clk);
        #1;
        check("run_alu_a", 32'(alu_a), 32'h03);
        check("run_alu_b", 32'(alu_b), 32'h01);
        check("run_alu_c_in", 32'(alu_c_in), 32'd0);
        check("run_alu_op", 32'(alu_op), 32'd2);
        @(posedge clk);
        #1;
        check("partial_sum", sum, 32'h00000405);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", sum, 32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - dc), 32'd0);

        issue(0, 0, 32'h80000000, 32'h80000000, 32'h00000000, 1, 1, 1);
        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
